// File: rtl/alu_packet_engine_if.sv
// Packet bus between producer, alu_packet_engine and consumer.
// Request side: data_in/valid_in/cmd_in/in_ready; response side: data_out/valid_out/cmd_out/out_ready.
interface alu_packet_engine_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic              cmd_in;
  logic              in_ready;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              cmd_out;
  logic              out_ready;

  modport master (
    output data_in, valid_in, cmd_in, out_ready,
    input  in_ready, data_out, valid_out, cmd_out
  );

  modport slave (
    input  data_in, valid_in, cmd_in, out_ready,
    output in_ready, data_out, valid_out, cmd_out
  );
endinterface

// File: rtl/alu_packet_engine.sv
// Packet ALU: header + N operands folded by opcode, answered by header + result beats.
// Ports: clk, rst_n (async, active-low), bus (slave side of alu_packet_engine_if).
module alu_packet_engine #(
  parameter int          DATA_W  = 16,
  parameter int          MAX_OPS = 32,
  parameter logic [15:0] ERR_HDR = 16'h0010,
  parameter logic [15:0] ERR_PAY = 16'h0BAD
) (
  input logic                clk,
  input logic                rst_n,
  alu_packet_engine_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_SEND_HDR,
    S_SEND_PAY
  } state_e;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_AND = 4'd1;
  localparam logic [3:0] OP_OR  = 4'd2;
  localparam logic [3:0] OP_XOR = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_INC = 4'd5;
  localparam logic [3:0] OP_DEC = 4'd6;
  localparam logic [3:0] OP_NEG = 4'd7;
  localparam logic [3:0] OP_SUB = 4'd8;
  localparam logic [3:0] OP_MAX = 4'd9;
  localparam logic [3:0] OP_MIN = 4'd10;

  localparam logic [6:0]        MAX_N     = 7'(MAX_OPS);
  localparam logic [DATA_W-1:0] ONE       = DATA_W'(1);
  localparam logic [DATA_W-1:0] ERR_HDR_W = DATA_W'(ERR_HDR);
  localparam logic [DATA_W-1:0] ERR_PAY_W = DATA_W'(ERR_PAY);

  function automatic logic [DATA_W-1:0] fold(
    input logic [3:0]        op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [DATA_W-1:0] r;
    r = a;
    case (op)
      OP_ADD:  r = a + b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SUB:  r = a - b;
      OP_MAX:  r = (b > a) ? b : a;
      OP_MIN:  r = (b < a) ? b : a;
      default: r = a;
    endcase
    return r;
  endfunction

  // Unary ops only ever see a single operand, so they are
  // applied as that operand is loaded.
  function automatic logic [DATA_W-1:0] unary(
    input logic [3:0]        op,
    input logic [DATA_W-1:0] x
  );
    logic [DATA_W-1:0] r;
    r = x;
    case (op)
      OP_NOT:  r = ~x;
      OP_INC:  r = x + ONE;
      OP_DEC:  r = x - ONE;
      OP_NEG:  r = -x;
      default: r = x;
    endcase
    return r;
  endfunction

  state_e            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [5:0]        n_q, n_d;
  logic [3:0]        op_q, op_d;
  logic              err_q, err_d;
  logic              live_q;

  logic [5:0]        hdr_n;
  logic [3:0]        hdr_op;
  logic              hdr_un;
  logic              hdr_bin;
  logic              hdr_err;
  logic              in_fire;
  logic [DATA_W-1:0] first_v;
  logic [DATA_W-1:0] fold_v;

  assign hdr_n   = bus.data_in[5:0];
  assign hdr_op  = bus.data_in[9:6];
  assign hdr_un  = (hdr_op >= OP_NOT) && (hdr_op <= OP_NEG);
  assign hdr_bin = (hdr_op <= OP_MIN) && !hdr_un;
  assign hdr_err = (hdr_n == 6'd0)
                || ({1'b0, hdr_n} > MAX_N)
                || (hdr_un && hdr_n != 6'd1)
                || (hdr_bin && hdr_n < 6'd2)
                || (!hdr_un && !hdr_bin);

  assign first_v = unary(op_q, bus.data_in);
  assign fold_v  = fold(op_q, acc_q, bus.data_in);

  // live_q keeps in_ready low until the first edge after reset.
  assign bus.in_ready = live_q
                     && (state_q == S_IDLE || state_q == S_COLLECT);
  assign in_fire      = bus.valid_in && bus.in_ready;

  assign bus.valid_out = (state_q == S_SEND_HDR)
                      || (state_q == S_SEND_PAY);
  assign bus.cmd_out   = (state_q == S_SEND_HDR);
  assign bus.data_out  =
    (state_q == S_SEND_HDR) ? (err_q ? ERR_HDR_W : '0) :
    (state_q == S_SEND_PAY) ? (err_q ? ERR_PAY_W : acc_q) :
    '0;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    op_d    = op_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE, S_COLLECT: begin
        // A header mid-packet silently drops the packet in progress.
        if (in_fire && bus.cmd_in) begin
          n_d     = hdr_n;
          op_d    = hdr_op;
          err_d   = hdr_err;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = (hdr_n == 6'd0) ? S_SEND_HDR : S_COLLECT;
        end else if (in_fire && state_q == S_COLLECT) begin
          cnt_d = cnt_q + 6'd1;
          if (!err_q) begin
            acc_d = (cnt_q == 6'd0) ? first_v : fold_v;
          end
          if (cnt_d == n_q) begin
            state_d = S_SEND_HDR;
          end
        end
      end
      S_SEND_HDR: begin
        if (bus.out_ready) state_d = S_SEND_PAY;
      end
      S_SEND_PAY: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      n_q     <= '0;
      op_q    <= '0;
      err_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      op_q    <= op_d;
      err_q   <= err_d;
      live_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_packet_engine.sv
// Bench for alu_packet_engine: 16- and 32-bit instances driven in lockstep.
// Directed scenarios plus randomized packets checked against a behavioural model.
module tb_alu_packet_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] din = '0;
  logic        valid_in = 1'b0;
  logic        cmd_in = 1'b0;
  logic        out_ready = 1'b1;

  int passed = 0;
  int total  = 0;

  logic [32:0] q16[$];
  logic [32:0] q32[$];

  alu_packet_engine_if #(.DATA_W(16)) b16();
  alu_packet_engine_if #(.DATA_W(32)) b32();

  assign b16.data_in   = din[15:0];
  assign b16.valid_in  = valid_in;
  assign b16.cmd_in    = cmd_in;
  assign b16.out_ready = out_ready;
  assign b32.data_in   = din;
  assign b32.valid_in  = valid_in;
  assign b32.cmd_in    = cmd_in;
  assign b32.out_ready = out_ready;

  alu_packet_engine #(.DATA_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(b16)
  );
  alu_packet_engine #(.DATA_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .bus(b32)
  );

  always #5 clk = ~clk;

  // Response beats recorded as {cmd, data} at the negedge before transfer.
  always @(negedge clk) begin
    if (b16.valid_out && b16.out_ready)
      q16.push_back({b16.cmd_out, 16'h0, b16.data_out});
    if (b32.valid_out && b32.out_ready)
      q32.push_back({b32.cmd_out, b32.data_out});
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired: passed=%0d total=%0d", passed, total);
    $fatal(1, "watchdog");
  end

  // Reference: result of a packet from the opcode rules, plain arithmetic.
  function automatic void model(
    input  logic [31:0] hdr,
    input  logic [31:0] ops[$],
    input  int          w,
    output logic [32:0] eh,
    output logic [32:0] ep
  );
    int n, op;
    bit un, bad;
    logic [31:0] mask, r, x;
    n    = int'(hdr[5:0]);
    op   = int'(hdr[9:6]);
    un   = (op >= 4 && op <= 7);
    bad  = (n == 0) || (n > 32) || (op > 10) || (un ? n != 1 : n < 2);
    mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    if (bad) begin
      eh = {1'b1, 32'h10};
      ep = {1'b0, 32'hBAD};
      return;
    end
    r = ops[0] & mask;
    for (int i = 1; i < n; i++) begin
      x = ops[i] & mask;
      case (op)
        0: r = r + x;
        1: r = r & x;
        2: r = r | x;
        3: r = r ^ x;
        8: r = r - x;
        9: r = (x > r) ? x : r;
        default: r = (x < r) ? x : r;
      endcase
    end
    case (op)
      4: r = ~r;
      5: r = r + 1;
      6: r = r - 1;
      7: r = 0 - r;
      default: ;
    endcase
    eh = {1'b1, 32'h0};
    ep = {1'b0, r & mask};
  endfunction

  task automatic send_beat(input logic [31:0] d, input bit c,
                           output int st, output bit ok);
    din = d;
    cmd_in = c;
    valid_in = 1'b1;
    st = 0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (b16.in_ready && b32.in_ready) begin
        ok = 1'b1;
        break;
      end
      st++;
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    cmd_in = 1'b0;
  endtask

  task automatic send_pkt(input logic [31:0] hdr, input logic [31:0] ops[$],
                          input int gap, output int stalls, output bit ok);
    int st;
    bit k;
    send_beat(hdr, 1'b1, st, k);
    stalls = st;
    ok = k;
    foreach (ops[i]) begin
      repeat ($urandom_range(0, gap)) begin
        @(posedge clk);
        #1;
      end
      send_beat(ops[i], 1'b0, st, k);
      stalls += st;
      ok = ok & k;
    end
  endtask

  task automatic wait_rsp(input int n, input bit rnd, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #1;
      if (q16.size() >= n && q32.size() >= n) begin
        ok = 1'b1;
        break;
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({b16.in_ready, b16.valid_out, b16.cmd_out, b16.data_out} !== 19'h0
     || {b32.in_ready, b32.valid_out, b32.cmd_out, b32.data_out} !== 35'h0) begin
      $display("FAIL reset_outputs got %b%b%b/%h %b%b%b/%h exp all zero",
        b16.in_ready, b16.valid_out, b16.cmd_out, b16.data_out,
        b32.in_ready, b32.valid_out, b32.cmd_out, b32.data_out);
    end else passed++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (b16.in_ready !== 1'b0 || b32.in_ready !== 1'b0)
      $display("FAIL reset_ready_early got %b %b exp 0",
        b16.in_ready, b32.in_ready);
    else passed++;
    @(negedge clk);
    total++;
    if (b16.in_ready !== 1'b1 || b32.in_ready !== 1'b1)
      $display("FAIL reset_ready_rise got %b %b exp 1",
        b16.in_ready, b32.in_ready);
    else passed++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [31:0] ops[$];
    logic [32:0] e16[2], e32[2];
    int st;
    bit ok, ok2;
    q16.delete(); q32.delete();
    ops = '{32'h00A0, 32'h000C};
    send_pkt(32'h0002, ops, 0, st, ok);
    total++;
    if (b16.valid_out !== 1'b1 || b16.cmd_out !== 1'b1)
      $display("FAIL basic_latency got valid=%b cmd=%b exp 1 1",
        b16.valid_out, b16.cmd_out);
    else passed++;
    wait_rsp(2, 1'b0, ok2);
    total++;
    if (!(ok && ok2)) $display("FAIL basic_timeout got %b%b exp 11", ok, ok2);
    else passed++;
    e16 = '{33'h1_0000_0000, 33'h0_0000_00AC};
    e32 = '{33'h1_0000_0000, 33'h0_0000_00AC};
    for (int i = 0; i < 2; i++) begin
      total++;
      if (q16[i] !== e16[i]) $display("FAIL basic16[%0d] got %h exp %h", i, q16[i], e16[i]);
      else passed++;
      total++;
      if (q32[i] !== e32[i]) $display("FAIL basic32[%0d] got %h exp %h", i, q32[i], e32[i]);
      else passed++;
    end
  endtask

  task automatic test_arity_error();
    logic [31:0] ops[$];
    logic [32:0] e16[4], e32[4];
    int st;
    bit ok, ok2;
    q16.delete(); q32.delete();
    ops = '{32'h1111, 32'h2222, 32'h3333};
    send_pkt(32'h0143, ops, 0, st, ok);
    total++;
    if (st !== 0) $display("FAIL arity_stalls got %0d exp 0", st);
    else passed++;
    wait_rsp(2, 1'b0, ok2);
    ops = '{32'h0000_0001};
    send_pkt(32'h01C1, ops, 0, st, ok);
    wait_rsp(4, 1'b0, ok2);
    total++;
    if (!(ok && ok2)) $display("FAIL arity_timeout got %b%b exp 11", ok, ok2);
    else passed++;
    e16 = '{33'h1_0000_0010, 33'h0_0000_0BAD, 33'h1_0000_0000, 33'h0_0000_FFFF};
    e32 = '{33'h1_0000_0010, 33'h0_0000_0BAD, 33'h1_0000_0000, 33'h0_FFFF_FFFF};
    for (int i = 0; i < 4; i++) begin
      total++;
      if (q16[i] !== e16[i]) $display("FAIL arity16[%0d] got %h exp %h", i, q16[i], e16[i]);
      else passed++;
      total++;
      if (q32[i] !== e32[i]) $display("FAIL arity32[%0d] got %h exp %h", i, q32[i], e32[i]);
      else passed++;
    end
  endtask

  task automatic test_sub_wrap();
    logic [31:0] ops[$];
    int st;
    bit ok, ok2;
    q16.delete(); q32.delete();
    ops = '{32'h5, 32'h3, 32'h4};
    send_pkt(32'h0203, ops, 2, st, ok);
    wait_rsp(2, 1'b0, ok2);
    total++;
    if (!(ok && ok2) || q16[1] !== 33'h0_0000_FFFE)
      $display("FAIL sub16 got %h exp %h", q16[1], 33'h0_0000_FFFE);
    else passed++;
    total++;
    if (q32[1] !== 33'h0_FFFF_FFFE)
      $display("FAIL sub32 got %h exp %h", q32[1], 33'h0_FFFF_FFFE);
    else passed++;
  endtask

  task automatic test_abort();
    int st;
    bit k, ok;
    q16.delete(); q32.delete();
    ok = 1'b1;
    send_beat(32'h0004, 1'b1, st, k); ok = ok & k;
    send_beat(32'h0001, 1'b0, st, k); ok = ok & k;
    send_beat(32'h0002, 1'b0, st, k); ok = ok & k;
    send_beat(32'h0141, 1'b1, st, k); ok = ok & k;
    send_beat(32'hFFFF, 1'b0, st, k); ok = ok & k;
    wait_rsp(2, 1'b0, k);
    ok = ok & k;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (!ok || q16.size() != 2 || q32.size() != 2)
      $display("FAIL abort_count got %0d/%0d exp 2", q16.size(), q32.size());
    else passed++;
    total++;
    if (q16[0] !== 33'h1_0000_0000 || q16[1] !== 33'h0_0000_0000)
      $display("FAIL abort16 got %h %h exp 100000000 000000000", q16[0], q16[1]);
    else passed++;
    total++;
    if (q32[0] !== 33'h1_0000_0000 || q32[1] !== 33'h0_0001_0000)
      $display("FAIL abort32 got %h %h exp 100000000 000010000", q32[0], q32[1]);
    else passed++;
  endtask

  task automatic test_backpressure();
    logic [31:0] ops[$];
    int st;
    bit ok, ok2;
    q16.delete(); q32.delete();
    out_ready = 1'b0;
    ops = '{32'h0010, 32'hFFF0, 32'h0100};
    send_pkt(32'h0243, ops, 0, st, ok);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({b16.valid_out, b16.cmd_out, b16.data_out, b16.in_ready} !== {2'b11, 16'h0, 1'b0}
       || {b32.valid_out, b32.cmd_out, b32.data_out, b32.in_ready} !== {2'b11, 32'h0, 1'b0})
        $display("FAIL bp_hdr_hold got %b%b%h%b exp 1100000", b16.valid_out,
          b16.cmd_out, b16.data_out, b16.in_ready);
      else passed++;
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({b16.valid_out, b16.cmd_out, b16.data_out, b16.in_ready} !== {2'b10, 16'hFFF0, 1'b0}
       || {b32.valid_out, b32.cmd_out, b32.data_out, b32.in_ready} !== {2'b10, 32'hFFF0, 1'b0})
        $display("FAIL bp_pay_hold got %b%b%h%b exp 10fff00", b16.valid_out,
          b16.cmd_out, b16.data_out, b16.in_ready);
      else passed++;
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_rsp(2, 1'b0, ok2);
    total++;
    if (!(ok && ok2) || q16.size() != 2 || q16[1] !== 33'h0_0000_FFF0 || q32[1] !== 33'h0_0000_FFF0)
      $display("FAIL bp_result got %h %h exp 00000fff0", q16[1], q32[1]);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] ops[$];
    int st, st2;
    bit ok, k, ok2;
    q16.delete(); q32.delete();
    ops = '{32'h3, 32'h4};
    send_pkt(32'h0002, ops, 0, st, ok);
    send_beat(32'h00C2, 1'b1, st2, k); ok = ok & k;
    send_beat(32'hF0F0, 1'b0, st, k); ok = ok & k;
    send_beat(32'h0FF0, 1'b0, st, k); ok = ok & k;
    wait_rsp(4, 1'b0, ok2);
    total++;
    if (st2 != 2) $display("FAIL b2b_hdr_wait got %0d exp 2", st2);
    else passed++;
    total++;
    if (!(ok && ok2) || q16[1] !== 33'h0_0000_0007 || q16[3] !== 33'h0_0000_FF00
        || q32[3] !== 33'h0_0000_FF00)
      $display("FAIL b2b_results got %h %h %h exp 000000007 00000ff00", q16[1], q16[3], q32[3]);
    else passed++;
  endtask

  task automatic test_bad_n();
    logic [31:0] ops[$];
    int st;
    bit ok, ok2;
    q16.delete(); q32.delete();
    send_beat(32'h0000, 1'b1, st, ok);
    total++;
    if (b16.valid_out !== 1'b1 || b16.data_out !== 16'h0010)
      $display("FAIL n0_immediate got %b/%h exp 1/0010", b16.valid_out, b16.data_out);
    else passed++;
    wait_rsp(2, 1'b0, ok2);
    ops.delete();
    for (int i = 0; i < 33; i++) ops.push_back($urandom);
    send_pkt(32'h0021, ops, 0, st, ok);
    wait_rsp(4, 1'b0, ok2);
    total++;
    if (!(ok && ok2) || q16[1] !== 33'h0_0000_0BAD || q16[2] !== 33'h1_0000_0010
        || q32[3] !== 33'h0_0000_0BAD)
      $display("FAIL bad_n got %h %h %h exp 000000bad 100000010 000000bad", q16[1], q16[2], q32[3]);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] ops[$];
    int st;
    bit ok, ok2;
    q16.delete(); q32.delete();
    out_ready = 1'b0;
    ops = '{32'h7, 32'h8};
    send_pkt(32'h0002, ops, 0, st, ok);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({b16.valid_out, b16.cmd_out, b16.data_out, b16.in_ready} !== 19'h0
     || b32.valid_out !== 1'b0)
      $display("FAIL rst_mid got %b%b%h%b exp all zero", b16.valid_out,
        b16.cmd_out, b16.data_out, b16.in_ready);
    else passed++;
    @(posedge clk); #1 rst_n = 1'b1;
    out_ready = 1'b1;
    wait_rsp(2, 1'b0, ok2);
    total++;
    if (!ok || q16.size() != 1 || q32.size() != 1)
      $display("FAIL rst_mid_partial got %0d/%0d beats exp 1", q16.size(), q32.size());
    else passed++;
  endtask

  task automatic test_random();
    logic [31:0] ops[$];
    logic [31:0] hdr;
    logic [32:0] eh16, ep16, eh32, ep32;
    int n, op, st;
    bit ok, ok2;
    for (int p = 0; p < 30; p++) begin
      q16.delete(); q32.delete();
      if ($urandom_range(0, 4) == 0) begin
        op = $urandom_range(0, 15);
        n  = $urandom_range(0, 5);
      end else begin
        op = $urandom_range(0, 10);
        n  = (op >= 4 && op <= 7) ? 1 : $urandom_range(2, 6);
      end
      hdr = {$urandom_range(0, 65535), 16'h0} | 32'(op << 6) | 32'(n);
      ops.delete();
      for (int i = 0; i < n; i++)
        ops.push_back($urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF : $urandom);
      model(hdr, ops, 16, eh16, ep16);
      model(hdr, ops, 32, eh32, ep32);
      if ($urandom_range(0, 3) == 0) send_beat($urandom, 1'b0, st, ok);
      send_pkt(hdr, ops, 2, st, ok);
      wait_rsp(2, 1'b1, ok2);
      total++;
      if (!(ok && ok2) || q16[0] !== eh16 || q16[1] !== ep16)
        $display("FAIL rand16 p%0d hdr=%h got %h %h exp %h %h", p, hdr, q16[0], q16[1], eh16, ep16);
      else passed++;
      total++;
      if (q32[0] !== eh32 || q32[1] !== ep32)
        $display("FAIL rand32 p%0d hdr=%h got %h %h exp %h %h", p, hdr, q32[0], q32[1], eh32, ep32);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_arity_error();
    test_sub_wrap();
    test_abort();
    test_backpressure();
    test_back_to_back();
    test_bad_n();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
